// File: rtl/kgp_mem_pkg.sv
// kgp_mem_pkg: size codes, FSM state codes and narrowing helpers for store_narrow_unit.
package kgp_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  localparam logic [2:0] S_IDLE = 3'd0, S_RD = 3'd1, S_MRG = 3'd2, S_WR = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_BYTE || (size == SZ_HALF && !lane[0]) || (size == SZ_WORD && lane == 2'b00);
  endfunction
  // Narrowing loses information unless every dropped bit equals the new sign bit.
  function automatic logic is_trunc(input logic [1:0] size, input logic [31:0] w);
    return size == SZ_BYTE ? !(&w[31:7] || ~|w[31:7]) :
           size == SZ_HALF ? !(&w[31:15] || ~|w[31:15]) : 1'b0;
  endfunction
endpackage

// File: rtl/store_narrow_unit_if.sv
// store_narrow_unit_if: request/response and data-memory port of the store narrowing unit.
interface store_narrow_unit_if #(parameter int ADDR_W = 10);
  logic start;
  logic [ADDR_W+1:0] addr;
  logic [1:0] size;
  logic [31:0] wdata;
  logic busy, done, err, trunc;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_re, mem_we;
  logic [31:0] mem_rdata, mem_wdata;
  modport master(output start, addr, size, wdata, mem_rdata,
                 input busy, done, err, trunc, mem_addr, mem_re, mem_we, mem_wdata);
  modport slave(input start, addr, size, wdata, mem_rdata,
                output busy, done, err, trunc, mem_addr, mem_re, mem_we, mem_wdata);
endinterface

// File: rtl/lane_merge.sv
// lane_merge: replaces the addressed byte/halfword lane of an old word with narrowed store data.
module lane_merge
  import kgp_mem_pkg::*;
(
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);
  always_comb begin
    merged = old;
    if (size == SZ_BYTE) merged[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_HALF) merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
endmodule

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a register value to byte/half/word and stores it via read-modify-write.
module store_narrow_unit
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst_n,
  store_narrow_unit_if.slave bus
);
  logic [2:0] state, state_n;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0] size_q;
  logic [31:0] data_q, wd_q, merged;
  logic trunc_q;
  lane_merge u_merge (
    .old(bus.mem_rdata), .wdata(data_q), .size(size_q), .lane(addr_q[1:0]), .merged(merged)
  );
  assign state_n = state == S_IDLE ? (!bus.start ? S_IDLE :
                                      !is_legal(bus.size, bus.addr[1:0]) ? S_ERR :
                                      bus.size == SZ_WORD ? S_WR : S_RD) :
                   state == S_RD  ? S_MRG :
                   state == S_MRG ? S_WR :
                   state == S_WR  ? S_DONE : S_IDLE;
  // Word stores preload the write word at accept; sub-word stores overwrite it in MRG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr_q <= '0;
      size_q <= '0;
      data_q <= '0;
      wd_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.start) begin
        addr_q <= bus.addr;
        size_q <= bus.size;
        data_q <= bus.wdata;
        wd_q <= bus.wdata;
        trunc_q <= is_trunc(bus.size, bus.wdata);
      end
      if (state == S_MRG) wd_q <= merged;
    end
  end
  assign bus.busy = state == S_RD || state == S_MRG || state == S_WR;
  assign bus.done = state == S_DONE || state == S_ERR;
  assign bus.err = state == S_ERR;
  assign bus.trunc = state == S_DONE && trunc_q;
  assign bus.mem_re = state == S_RD;
  assign bus.mem_we = state == S_WR;
  assign bus.mem_addr = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata = wd_q;
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed vector table plus busy and mid-operation reset sequences.
module tb_store_narrow_unit;
  import kgp_mem_pkg::*;
  localparam int ADDR_W = 10;
  typedef struct {
    logic [11:0] a;
    logic [1:0]  s;
    logic [31:0] w;
    logic [31:0] pre;
    int          lat;
    logic        e;
    logic        t;
    int          re;
    int          we;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] mem [0:1023];
  int n_cmp = 0, n_bad = 0, re_cnt = 0, we_cnt = 0, both_cnt = 0;
  vec_t vt [0:10];
  store_narrow_unit_if #(.ADDR_W(ADDR_W)) bus ();
  store_narrow_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mem_rdata = rdata;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_re) begin
      rdata = mem[bus.mem_addr];
      re_cnt++;
    end
    if (bus.mem_we) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      we_cnt++;
    end
    if (bus.mem_re && bus.mem_we) both_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {26'b0, bus.busy, bus.done, bus.err, bus.trunc, bus.mem_re, bus.mem_we}, 32'h0);
    chk({tag, "_maddr"}, {22'b0, bus.mem_addr}, 32'h0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 32'h0);
  endtask
  task automatic do_req(input logic [11:0] a, input logic [1:0] s, input logic [31:0] w,
                        input int poke, output int lat, output logic e, output logic t);
    lat = -1;
    e = 1'b0;
    t = 1'b0;
    @(negedge clk);
    re_cnt = 0;
    we_cnt = 0;
    both_cnt = 0;
    bus.start = 1'b1;
    bus.addr = a;
    bus.size = s;
    bus.wdata = w;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      bus.start = (k == poke);
      if (k == poke) begin
        bus.addr = 12'h030;
        bus.size = SZ_WORD;
        bus.wdata = 32'h99;
      end
      if (bus.done) begin
        lat = k;
        e = bus.err;
        t = bus.trunc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("idle_after_done", {30'b0, bus.busy, bus.done}, 32'h0);
  endtask
  initial begin
    int lat;
    logic e, t;
    bus.start = 1'b0;
    bus.addr = '0;
    bus.size = '0;
    bus.wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    vt[0]  = '{12'h015, SZ_BYTE, 32'h00000011, 32'hAABBCCDD, 4, 1'b0, 1'b0, 1, 1, 32'hAABB11DD};
    vt[1]  = '{12'h00A, SZ_HALF, 32'hFFFF8001, 32'h12345678, 4, 1'b0, 1'b0, 1, 1, 32'h80015678};
    vt[2]  = '{12'h00A, SZ_HALF, 32'h00018001, 32'h12345678, 4, 1'b0, 1'b1, 1, 1, 32'h80015678};
    vt[3]  = '{12'h020, SZ_WORD, 32'hDEADBEEF, 32'h00000000, 2, 1'b0, 1'b0, 0, 1, 32'hDEADBEEF};
    vt[4]  = '{12'h003, SZ_HALF, 32'h00018001, 32'h55555555, 1, 1'b1, 1'b0, 0, 0, 32'h55555555};
    vt[5]  = '{12'h002, SZ_WORD, 32'h00000001, 32'h55555555, 1, 1'b1, 1'b0, 0, 0, 32'h55555555};
    vt[6]  = '{12'h004, 2'b11,   32'h12345678, 32'h66666666, 1, 1'b1, 1'b0, 0, 0, 32'h66666666};
    vt[7]  = '{12'h01F, SZ_BYTE, 32'hFFFFFF80, 32'h11223344, 4, 1'b0, 1'b0, 1, 1, 32'h80223344};
    vt[8]  = '{12'h004, SZ_BYTE, 32'h00000080, 32'hCAFEF00D, 4, 1'b0, 1'b1, 1, 1, 32'hCAFEF080};
    vt[9]  = '{12'h00C, SZ_HALF, 32'h00007FFF, 32'hA5A5A5A5, 4, 1'b0, 1'b0, 1, 1, 32'hA5A57FFF};
    vt[10] = '{12'h00E, SZ_HALF, 32'hFFFF8000, 32'hA5A5A5A5, 4, 1'b0, 1'b0, 1, 1, 32'h8000A5A5};
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      mem[vt[i].a[11:2]] = vt[i].pre;
      do_req(vt[i].a, vt[i].s, vt[i].w, 0, lat, e, t);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].e));
      chk($sformatf("v%0d_trunc", i), 32'(t), 32'(vt[i].t));
      chk($sformatf("v%0d_re_count", i), re_cnt, vt[i].re);
      chk($sformatf("v%0d_we_count", i), we_cnt, vt[i].we);
      chk($sformatf("v%0d_re_we_overlap", i), both_cnt, 0);
      chk($sformatf("v%0d_mem", i), mem[vt[i].a[11:2]], vt[i].exp);
    end
    // Second start while busy must be ignored.
    mem[9] = 32'h0;
    mem[12] = 32'h5A5A5A5A;
    do_req(12'h024, SZ_BYTE, 32'hAB, 1, lat, e, t);
    chk("busy_latency", lat, 4);
    chk("busy_we_count", we_cnt, 1);
    chk("busy_re_count", re_cnt, 1);
    chk("busy_mem", mem[9], 32'h000000AB);
    chk("busy_ignored_mem", mem[12], 32'h5A5A5A5A);
    // Reset asserted in MRG abandons the store.
    mem[6] = 32'h01020304;
    @(negedge clk);
    re_cnt = 0;
    we_cnt = 0;
    bus.start = 1'b1;
    bus.addr = 12'h018;
    bus.size = SZ_BYTE;
    bus.wdata = 32'h77;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("mrg_busy", {31'b0, bus.busy}, 32'h1);
    chk("mrg_maddr", {22'b0, bus.mem_addr}, 32'h6);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_we", we_cnt, 0);
    chk("midrst_mem_kept", mem[6], 32'h01020304);
    do_req(12'h018, SZ_BYTE, 32'h77, 0, lat, e, t);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_err", 32'(e), 32'h0);
    chk("after_rst_mem", mem[6], 32'h01020377);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
